// File: rtl/hps_reset_sequencer.sv
// hps_reset_sequencer
// Serialises the cold / warm / debug HPS reset requests from the source/probe
// into non-overlapping, fixed-width, active-high request pulses. The top level
// inverts them onto the active-low f2h_*_reset_req pins.
//
// Optional build macro: HPS_RST_SEQ_STATS_EN
//   defined   -> saturating 8-bit served-request counters are built
//   undefined -> cold_cnt / warm_cnt / debug_cnt are tied to 0
//
// Parameters
//   COLD_PULSE, WARM_PULSE, DEBUG_PULSE : pulse widths in clocks (>=1)
//   HOLDOFF                             : dead time after any pulse (>=1)
// Ports
//   clk               : FPGA_CLK1_50, the only clock
//   rst               : synchronous active-high reset
//   hps_fpga_reset_n  : request gate; while low new requests are discarded
//   req[2:0]          : level requests {debug, warm, cold}
//   cold_reset        : registered cold request pulse
//   warm_reset        : registered warm request pulse
//   debug_reset       : registered debug request pulse
//   busy              : high while a pulse or its holdoff is in progress
//   pending[2:0]      : latched requests not yet served, same order as req
//   cold_cnt/warm_cnt/debug_cnt : served-request counters (stats build only)

module hps_reset_sequencer #(
    parameter int unsigned COLD_PULSE  = 6,
    parameter int unsigned WARM_PULSE  = 2,
    parameter int unsigned DEBUG_PULSE = 32,
    parameter int unsigned HOLDOFF     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hps_fpga_reset_n,
    input  logic [2:0] req,
    output logic       cold_reset,
    output logic       warm_reset,
    output logic       debug_reset,
    output logic       busy,
    output logic [2:0] pending,
    output logic [7:0] cold_cnt,
    output logic [7:0] warm_cnt,
    output logic [7:0] debug_cnt
);

    localparam int unsigned MAX_CW  = (COLD_PULSE > WARM_PULSE) ? COLD_PULSE : WARM_PULSE;
    localparam int unsigned MAX_DH  = (DEBUG_PULSE > HOLDOFF) ? DEBUG_PULSE : HOLDOFF;
    localparam int unsigned MAX_ALL = (MAX_CW > MAX_DH) ? MAX_CW : MAX_DH;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

    // One-hot request masks, same bit order as req
    localparam logic [2:0] MASK_COLD  = 3'b001;
    localparam logic [2:0] MASK_WARM  = 3'b010;
    localparam logic [2:0] MASK_DEBUG = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         sel_q;
    logic [2:0]         sel_d;
    logic [2:0]         req_q;
    logic               armed_q;
    logic [2:0]         rise;
    logic [2:0]         pend_eff;
    logic [2:0]         start_mask;
    logic [2:0]         pending_d;
    logic [2:0]         out_d;
    logic               busy_d;

    // State, counter, selection, edge detector and pending latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            req_q   <= '0;
            armed_q <= 1'b0;
            pending <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            req_q   <= req;
            armed_q <= 1'b1;
            pending <= pending_d;
        end
    end

    // Rising-edge requests; the first cycle after reset only primes req_q so a
    // level already high at reset release is not mistaken for a new request
    always_comb begin
        rise     = armed_q ? (req & ~req_q) : 3'b000;
        pend_eff = hps_fpga_reset_n ? pending : 3'b000;
    end

    // Next-state: arbitration, pulse/holdoff countdown, cold preemption
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        start_mask = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (pend_eff[0]) begin
                    state_d    = ST_PULSE;
                    sel_d      = MASK_COLD;
                    cnt_d      = CNT_W'(COLD_PULSE);
                    start_mask = MASK_COLD;
                end else if (pend_eff[1]) begin
                    state_d    = ST_PULSE;
                    sel_d      = MASK_WARM;
                    cnt_d      = CNT_W'(WARM_PULSE);
                    start_mask = MASK_WARM;
                end else if (pend_eff[2]) begin
                    state_d    = ST_PULSE;
                    sel_d      = MASK_DEBUG;
                    cnt_d      = CNT_W'(DEBUG_PULSE);
                    start_mask = MASK_DEBUG;
                end
            end

            ST_PULSE: begin
                if (pend_eff[0] && !sel_q[0]) begin
                    // Cold aborts a warm/debug pulse and restarts at once;
                    // the aborted request is already out of pending
                    sel_d      = MASK_COLD;
                    cnt_d      = CNT_W'(COLD_PULSE);
                    start_mask = MASK_COLD;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = CNT_W'(HOLDOFF);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_HOLDOFF: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sel_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sel_d   = '0;
            end
        endcase

        // A rise on the bit being started wins over its clear
        pending_d = hps_fpga_reset_n ? ((pending & ~start_mask) | rise) : 3'b000;
    end

    // Output decode from the next state so the registered pulses line up
    // with the state register
    always_comb begin
        out_d  = 3'b000;
        busy_d = 1'b0;
        if (state_d == ST_PULSE) begin
            out_d = sel_d;
        end
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cold_reset  <= 1'b0;
            warm_reset  <= 1'b0;
            debug_reset <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cold_reset  <= out_d[0];
            warm_reset  <= out_d[1];
            debug_reset <= out_d[2];
            busy        <= busy_d;
        end
    end

`ifdef HPS_RST_SEQ_STATS_EN
    // Saturating counts of pulse starts, preempted pulses included
    always_ff @(posedge clk) begin
        if (rst) begin
            cold_cnt  <= '0;
            warm_cnt  <= '0;
            debug_cnt <= '0;
        end else begin
            if (start_mask[0] && (cold_cnt != 8'hFF)) begin
                cold_cnt <= cold_cnt + 8'd1;
            end
            if (start_mask[1] && (warm_cnt != 8'hFF)) begin
                warm_cnt <= warm_cnt + 8'd1;
            end
            if (start_mask[2] && (debug_cnt != 8'hFF)) begin
                debug_cnt <= debug_cnt + 8'd1;
            end
        end
    end
`else
    assign cold_cnt  = 8'd0;
    assign warm_cnt  = 8'd0;
    assign debug_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed testbench for hps_reset_sequencer with default parameters.
// Expected counter values follow HPS_RST_SEQ_STATS_EN (0 when undefined).

module tb_hps_reset_sequencer;

`ifdef HPS_RST_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       gate;
    logic [2:0] req;
    logic       cold_reset;
    logic       warm_reset;
    logic       debug_reset;
    logic       busy;
    logic [2:0] pending;
    logic [7:0] cold_cnt;
    logic [7:0] warm_cnt;
    logic [7:0] debug_cnt;
    logic [2:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign outs = {debug_reset, warm_reset, cold_reset};

    hps_reset_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .hps_fpga_reset_n (gate),
        .req              (req),
        .cold_reset       (cold_reset),
        .warm_reset       (warm_reset),
        .debug_reset      (debug_reset),
        .busy             (busy),
        .pending          (pending),
        .cold_cnt         (cold_cnt),
        .warm_cnt         (warm_cnt),
        .debug_cnt        (debug_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 3'b000;
        gate = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 3'b111;
        gate = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs !== 3'b000) begin n_fail++; $display("FAIL reset_outs got=%b exp=000", outs); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (pending !== 3'b000) begin n_fail++; $display("FAIL reset_pending got=%b exp=000", pending); end
        n_checks++;
        if ({cold_cnt, warm_cnt, debug_cnt} !== 24'd0) begin
            n_fail++; $display("FAIL reset_cnts got=%h/%h/%h exp=0", cold_cnt, warm_cnt, debug_cnt);
        end
        // req held high through reset release must not fire
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_checks++;
            if ({outs, pending, busy} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_release c=%0d outs=%b pending=%b busy=%b exp=0", c, outs, pending, busy);
            end
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_single_warm();
        logic [2:0] exp_o;
        logic [2:0] exp_p;
        logic       exp_b;
        do_reset();
        req = 3'b010;
        for (int c = 1; c <= 25; c++) begin
            tick();
            exp_o = (c >= 2 && c <= 3) ? 3'b010 : 3'b000;
            exp_b = (c >= 2 && c <= 19);
            exp_p = (c == 1) ? 3'b010 : 3'b000;
            n_checks++;
            if (outs !== exp_o) begin n_fail++; $display("FAIL warm_outs c=%0d got=%b exp=%b", c, outs, exp_o); end
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL warm_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
            n_checks++;
            if (pending !== exp_p) begin n_fail++; $display("FAIL warm_pending c=%0d got=%b exp=%b", c, pending, exp_p); end
        end
        n_checks++;
        if (warm_cnt !== (STATS ? 8'd1 : 8'd0)) begin
            n_fail++; $display("FAIL warm_cnt got=%0d exp=%0d", warm_cnt, STATS ? 1 : 0);
        end
        req = 3'b000;
    endtask

    task automatic test_all_three();
        logic [2:0] exp_o;
        logic [2:0] exp_p;
        logic       exp_b;
        do_reset();
        req = 3'b111;
        for (int c = 1; c <= 95; c++) begin
            tick();
            if (c >= 2 && c <= 7)        exp_o = 3'b001;
            else if (c >= 25 && c <= 26) exp_o = 3'b010;
            else if (c >= 44 && c <= 75) exp_o = 3'b100;
            else                         exp_o = 3'b000;
            exp_b = (c >= 2 && c <= 23) || (c >= 25 && c <= 42) || (c >= 44 && c <= 91);
            if (c == 1)       exp_p = 3'b111;
            else if (c <= 24) exp_p = 3'b110;
            else if (c <= 43) exp_p = 3'b100;
            else              exp_p = 3'b000;
            n_checks++;
            if (outs !== exp_o) begin n_fail++; $display("FAIL all3_outs c=%0d got=%b exp=%b", c, outs, exp_o); end
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL all3_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
            n_checks++;
            if (pending !== exp_p) begin n_fail++; $display("FAIL all3_pending c=%0d got=%b exp=%b", c, pending, exp_p); end
            n_checks++;
            if (!$onehot0(outs)) begin n_fail++; $display("FAIL all3_overlap c=%0d got=%b exp=onehot0", c, outs); end
        end
        n_checks++;
        if ({cold_cnt, warm_cnt, debug_cnt} !== (STATS ? {8'd1, 8'd1, 8'd1} : 24'd0)) begin
            n_fail++; $display("FAIL all3_cnts got=%0d/%0d/%0d exp=%0d each", cold_cnt, warm_cnt, debug_cnt, STATS ? 1 : 0);
        end
        req = 3'b000;
    endtask

    task automatic test_preempt();
        logic [2:0] exp_o;
        logic [2:0] exp_p;
        logic       exp_b;
        do_reset();
        req = 3'b100;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c >= 2 && c <= 12)       exp_o = 3'b100;
            else if (c >= 13 && c <= 18) exp_o = 3'b001;
            else                         exp_o = 3'b000;
            exp_b = (c >= 2 && c <= 34);
            if (c == 1)       exp_p = 3'b100;
            else if (c == 12) exp_p = 3'b001;
            else              exp_p = 3'b000;
            n_checks++;
            if (outs !== exp_o) begin n_fail++; $display("FAIL preempt_outs c=%0d got=%b exp=%b", c, outs, exp_o); end
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL preempt_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
            n_checks++;
            if (pending !== exp_p) begin n_fail++; $display("FAIL preempt_pending c=%0d got=%b exp=%b", c, pending, exp_p); end
            if (c == 11) req = 3'b101;
        end
        n_checks++;
        if ({cold_cnt, debug_cnt} !== (STATS ? {8'd1, 8'd1} : 16'd0)) begin
            n_fail++; $display("FAIL preempt_cnts got=%0d/%0d exp=%0d each", cold_cnt, debug_cnt, STATS ? 1 : 0);
        end
        req = 3'b000;
    endtask

    task automatic test_gate();
        logic [2:0] exp_o;
        logic [2:0] exp_p;
        logic       exp_b;
        do_reset();
        req = 3'b010;
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp_o = (c >= 2 && c <= 3) ? 3'b010 : 3'b000;
            exp_b = (c >= 2 && c <= 19);
            exp_p = (c == 1) ? 3'b010 : 3'b000;
            n_checks++;
            if (outs !== exp_o) begin n_fail++; $display("FAIL gate_outs c=%0d got=%b exp=%b", c, outs, exp_o); end
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL gate_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
            n_checks++;
            if (pending !== exp_p) begin n_fail++; $display("FAIL gate_pending c=%0d got=%b exp=%b", c, pending, exp_p); end
            if (c == 2) begin
                gate = 1'b0;
                req  = 3'b110;
            end
            if (c == 25) gate = 1'b1;
        end
        n_checks++;
        if ({warm_cnt, debug_cnt} !== (STATS ? {8'd1, 8'd0} : 16'd0)) begin
            n_fail++; $display("FAIL gate_cnts got=%0d/%0d exp=%0d/0", warm_cnt, debug_cnt, STATS ? 1 : 0);
        end
        req = 3'b000;
    endtask

    task automatic test_rst_mid();
        logic [2:0] exp_o;
        logic [2:0] exp_p;
        logic       exp_b;
        do_reset();
        req = 3'b001;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp_o = (c >= 2 && c <= 4) ? 3'b001 : 3'b000;
            exp_b = (c >= 2 && c <= 4);
            exp_p = (c == 1) ? 3'b001 : 3'b000;
            n_checks++;
            if (outs !== exp_o) begin n_fail++; $display("FAIL rstmid_outs c=%0d got=%b exp=%b", c, outs, exp_o); end
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL rstmid_busy c=%0d got=%b exp=%b", c, busy, exp_b); end
            n_checks++;
            if (pending !== exp_p) begin n_fail++; $display("FAIL rstmid_pending c=%0d got=%b exp=%b", c, pending, exp_p); end
            if (c == 10) begin
                n_checks++;
                if (cold_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt_clr got=%0d exp=0", cold_cnt); end
            end
            if (c == 4) rst = 1'b1;
            if (c == 6) rst = 1'b0;
        end
        // Drop and re-raise: a fresh rise must be served again
        req = 3'b000;
        tick();
        tick();
        req = 3'b001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_o = (c >= 2) ? 3'b001 : 3'b000;
            n_checks++;
            if (outs !== exp_o) begin n_fail++; $display("FAIL rstmid_rearm c=%0d got=%b exp=%b", c, outs, exp_o); end
        end
        n_checks++;
        if (cold_cnt !== (STATS ? 8'd1 : 8'd0)) begin
            n_fail++; $display("FAIL rstmid_cnt got=%0d exp=%0d", cold_cnt, STATS ? 1 : 0);
        end
        req = 3'b000;
        repeat (25) tick();
    endtask

    task automatic test_stats();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            req = 3'b010;
            tick();
            req = 3'b000;
            repeat (19) tick();
            if (i == 100) begin
                n_checks++;
                if (warm_cnt !== (STATS ? 8'd100 : 8'd0)) begin
                    n_fail++; $display("FAIL stats_100 got=%0d exp=%0d", warm_cnt, STATS ? 100 : 0);
                end
            end
            if (i == 255) begin
                n_checks++;
                if (warm_cnt !== (STATS ? 8'd255 : 8'd0)) begin
                    n_fail++; $display("FAIL stats_255 got=%0d exp=%0d", warm_cnt, STATS ? 255 : 0);
                end
            end
        end
        n_checks++;
        if (warm_cnt !== (STATS ? 8'd255 : 8'd0)) begin
            n_fail++; $display("FAIL stats_sat got=%0d exp=%0d", warm_cnt, STATS ? 255 : 0);
        end
        n_checks++;
        if ({cold_cnt, debug_cnt} !== 16'd0) begin
            n_fail++; $display("FAIL stats_others got=%0d/%0d exp=0/0", cold_cnt, debug_cnt);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 3'b000;
        gate = 1'b1;
        test_reset();
        test_single_warm();
        test_all_three();
        test_preempt();
        test_gate();
        test_rst_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hps_reset_sequencer.md
# hps_reset_sequencer

Sequences the three HPS reset requests (cold, warm, debug) raised by the in-system source/probe onto the HPS `f2h_*_reset_req` inputs. It replaces three independent edge detectors with one arbitrated state machine, so two reset requests can never overlap and each pulse has an exact, configurable width. It sits in the top level between the `hps_reset` source/probe instance and `soc_system`. It runs on `FPGA_CLK1_50`, and its outputs are inverted at the top level to drive the active-low request pins.

## Interface
- `COLD_PULSE`, default 6: cold-request pulse width in clocks (≥1).
- `WARM_PULSE`, default 2: warm-request pulse width in clocks (≥1).
- `DEBUG_PULSE`, default 32: debug-request pulse width in clocks (≥1).
- `HOLDOFF`, default 16: dead time in clocks after any pulse before the next one may start (≥1).
- `clk` input 1: `FPGA_CLK1_50`; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `hps_fpga_reset_n` input 1: HPS-to-FPGA reset (active low), same clock domain; acts as a request gate, not a reset.
- `req` input 3: level requests from source/probe. Bit 0 is cold, bit 1 is warm, bit 2 is debug.
- `cold_reset`, `warm_reset`, `debug_reset` output 1 each: active-high, registered request pulses.
- `busy` output 1: high in PULSE or HOLDOFF.
- `pending` output 3: latched requests not yet served, same bit order as `req`.
- `cold_cnt`, `warm_cnt`, `debug_cnt` output 8 each: served-request counters; see Configuration.

## Operation
- Edge detection:
  - `req_q` registers `req`.
  - `rise = req & ~req_q`.
  - Only rising edges generate requests; held levels do not.
- Pending latch:
  - Each `rise` bit sets its `pending` bit.
  - A bit clears in the cycle its pulse starts.
  - A `rise` and a clear on the same bit in the same cycle leave the bit set, so a new request is never lost.
- Gate: while `hps_fpga_reset_n`=0:
  - `rise` is ignored and `pending` is cleared every cycle.
  - An in-progress PULSE or HOLDOFF runs to completion (busy requests are not interrupted).
- States:
  - IDLE: if `pending`≠0, select the highest priority (cold > warm > debug), load the counter with its pulse width and go to PULSE. Otherwise stay.
  - PULSE: drive the selected output high and decrement the counter. At count 1, load `HOLDOFF` and go to HOLDOFF.
  - HOLDOFF: all outputs low; decrement. At count 1, go to IDLE.
- Preemption:
  - A cold `rise` during a warm or debug PULSE aborts it immediately.
  - The aborted request is not re-queued.
  - Cold starts a fresh `COLD_PULSE` on the next cycle, with no holdoff.
  - Cold never preempts itself. A cold `rise` during a cold PULSE or during HOLDOFF is only latched.
- Simultaneous rises are all latched and served in priority order, each followed by HOLDOFF.
- Counter width: `$clog2(max(COLD_PULSE,WARM_PULSE,DEBUG_PULSE,HOLDOFF)+1)`, unsigned, with no wrap.
- At most one of the three reset outputs is high in any cycle.

## Timing
- Reset values:
  - All outputs 0.
  - `pending`=0 and `req_q`=0.
  - State is IDLE.
  - Counters are 0.
- Rise-to-output latency: with `req` going 0→1 before edge k and the block idle, `pending` sets at k. The output goes high after edge k+1 and stays high for exactly N clocks.
- Preemption latency: a cold rise sampled at edge k drops the old output and raises `cold_reset` both after edge k+1, with no gap cycle.
- `busy` rises in the same cycle as the pulse output. It falls `HOLDOFF` cycles after the pulse output falls.
- Minimum spacing between two pulses: `HOLDOFF`+1 cycles (HOLDOFF, then one IDLE arbitration cycle).
- `rst` mid-operation: the pulse is dropped on the next edge and all state returns to the reset values. `req` already high at reset release does not produce a rise.

## Configuration
- `HPS_RST_SEQ_STATS_EN` defined:
  - `cold_cnt`, `warm_cnt` and `debug_cnt` each increment by 1 in the cycle their pulse starts.
  - The counters saturate at 255.
  - Preempted pulses still count.
  - `rst` clears the counters.
- Not defined: the counter registers are not built and the three ports are tied to 0.
- Ports exist in both builds.

## Test plan
- Single warm rise with the block idle → `warm_reset` high for exactly 2 cycles, starting 2 edges after the rise; `busy` high for 18 cycles; `warm_cnt`=1.
- `req`=3'b111 rising in one cycle → cold (6), 16 holdoff, 1 idle, warm (2), 16 holdoff, 1 idle, debug (32); no two outputs ever high together; `pending` drains 111→110→100→000.
- Debug pulse at its 10th cycle, then cold rise → `debug_reset` low and `cold_reset` high on the same edge; cold lasts 6 cycles; debug is not re-served; `debug_cnt`=1 and `cold_cnt`=1.
- `hps_fpga_reset_n`=0 during a warm pulse, plus a new debug rise → the warm pulse completes its 2 cycles; the debug request is dropped; `pending`=0; the block returns to IDLE.
- `rst` asserted mid cold pulse with `req[0]` held high → all outputs 0 on the next edge; no new pulse after `rst` deasserts until `req[0]` goes low and then high again.
- Stats: with the macro, 300 warm rises spaced by 20 cycles → `warm_cnt`=255; without the macro → all counters read 0.
